// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with per-register busy/tag scoreboard
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int TAG_W    = 4,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rs_s,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rs_v,
    output logic [NUM_RD-1:0]              rs_busy,
    input  logic                           iss_we,
    input  logic [ADDR_W-1:0]              iss_rd,
    input  logic [TAG_W-1:0]               iss_tag,
    input  logic                           regf_we,
    input  logic [ADDR_W-1:0]              rd_s,
    input  logic [DATA_W-1:0]              rd_v,
    input  logic [TAG_W-1:0]               wb_tag,
    input  logic                           flush
);

    logic [DATA_W-1:0] data_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    // Per-register priority: flush/writeback clear first, issue overrides last.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (regf_we && rd_s == ADDR_W'(i)) begin
                    data_q[i] <= rd_v;
                end
                if (flush) begin
                    busy_q[i] <= 1'b0;
                end else if (regf_we && rd_s == ADDR_W'(i) && busy_q[i] && tag_q[i] == wb_tag) begin
                    busy_q[i] <= 1'b0;
                end
                if (iss_we && iss_rd == ADDR_W'(i)) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= iss_tag;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rs_v[p]    = '0;
            rs_busy[p] = 1'b0;
            if (!rst && rs_s[p] != '0) begin
                rs_v[p]    = data_q[rs_s[p]];
                rs_busy[p] = busy_q[rs_s[p]];
`ifdef REGFILE_BYPASS_EN
                // A same-cycle issue is not forwarded; only the writeback's effect is.
                if (regf_we && rs_s[p] == rd_s) begin
                    rs_v[p] = rd_v;
                    if (tag_q[rd_s] == wb_tag) begin
                        rs_busy[p] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule
